// File: rtl/tlc_top.sv
// Highway/farm-road traffic light controller: divides MCLK into a slow state tick,
// keeps sticky sensor requests and sequences the lamps with a Moore machine.
module tlc_top #(
  parameter int TICK_HALF = 125
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic HS_IN,
  input  logic FS_IN,
  output logic HGREEN,
  output logic HLEFT,
  output logic HYELLOW,
  output logic HRED,
  output logic FLEFT,
  output logic FYELLOW,
  output logic FRED,
  output logic TICK
);
  // state | meaning
  // HG    | highway green, farm red; idle until a request is snapshotted
  // HY1   | highway yellow leaving HG; picks left turn (priority) or farm
  // HL    | highway left turn, one tick
  // HY2   | highway yellow after left turn; farm next if pending
  // FL    | farm left, highway red, one tick
  // FY    | farm yellow, highway red, then back to HG
  typedef enum logic [2:0] {S_HG, S_HY1, S_HL, S_HY2, S_FL, S_FY} state_t;

  localparam int CW = $clog2(TICK_HALF);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clock_q, clock_d;
  logic          hs_req_q, hs_req_d, fs_req_q, fs_req_d;
  logic          hs_snap_q, hs_snap_d, fs_snap_q, fs_snap_d;
  logic          wrap, tick;
  logic [6:0]    lamps;

  assign wrap = (cnt_q == CW'(TICK_HALF - 1));
  assign tick = wrap & ~clock_q;

  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    clock_d   = wrap ? ~clock_q : clock_q;
    // The serving lamp clears its request even if the sensor is still high.
    hs_req_d  = (hs_req_q | HS_IN) & ~HLEFT;
    fs_req_d  = (fs_req_q | FS_IN) & ~FLEFT;
    hs_snap_d = tick ? hs_req_q : hs_snap_q;
    fs_snap_d = tick ? fs_req_q : fs_snap_q;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_HG:    if (hs_snap_q || fs_snap_q) state_d = S_HY1;
        S_HY1:   state_d = hs_snap_q ? S_HL : S_FL;
        S_HL:    state_d = S_HY2;
        S_HY2:   state_d = fs_snap_q ? S_FL : S_HG;
        S_FL:    state_d = S_FY;
        S_FY:    state_d = S_HG;
        default: state_d = S_HG;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cnt_q     <= '0;
      clock_q   <= 1'b0;
      state_q   <= S_HG;
      hs_req_q  <= 1'b0;
      fs_req_q  <= 1'b0;
      hs_snap_q <= 1'b0;
      fs_snap_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clock_q   <= clock_d;
      state_q   <= state_d;
      hs_req_q  <= hs_req_d;
      fs_req_q  <= fs_req_d;
      hs_snap_q <= hs_snap_d;
      fs_snap_q <= fs_snap_d;
    end
  end

  // Lamp order: {HRED,HYELLOW,HLEFT,HGREEN,FRED,FYELLOW,FLEFT}
  always_comb begin
    lamps = 7'b0001_100;
    case (state_q)
      S_HG:    lamps = 7'b0001_100;
      S_HY1:   lamps = 7'b0100_100;
      S_HL:    lamps = 7'b0010_100;
      S_HY2:   lamps = 7'b0100_100;
      S_FL:    lamps = 7'b1000_001;
      S_FY:    lamps = 7'b1000_010;
      default: lamps = 7'b0001_100;
    endcase
  end

  assign {HRED, HYELLOW, HLEFT, HGREEN, FRED, FYELLOW, FLEFT} = lamps;
  assign TICK = tick;

endmodule

// File: tb/tb_tlc_top.sv
// Directed bench for tlc_top: expected lamp vectors are queued per scenario and
// popped at each state tick.
module tb_tlc_top;
  localparam logic [6:0] L_HG = 7'b0001_100;
  localparam logic [6:0] L_HY = 7'b0100_100;
  localparam logic [6:0] L_HL = 7'b0010_100;
  localparam logic [6:0] L_FL = 7'b1000_001;
  localparam logic [6:0] L_FY = 7'b1000_010;

  logic MCLK = 1'b0;
  logic RESET = 1'b1;
  logic HS_IN = 1'b0;
  logic FS_IN = 1'b0;
  logic HGREEN, HLEFT, HYELLOW, HRED, FLEFT, FYELLOW, FRED, TICK;
  logic [6:0] lamps;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb[$];

  tlc_top #(.TICK_HALF(125)) dut (
    .MCLK(MCLK), .RESET(RESET), .HS_IN(HS_IN), .FS_IN(FS_IN),
    .HGREEN(HGREEN), .HLEFT(HLEFT), .HYELLOW(HYELLOW), .HRED(HRED),
    .FLEFT(FLEFT), .FYELLOW(FYELLOW), .FRED(FRED), .TICK(TICK)
  );

  assign lamps = {HRED, HYELLOW, HLEFT, HGREEN, FRED, FYELLOW, FLEFT};

  always #10 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Returns the number of MCLK edges up to and including the edge on which TICK was high.
  task automatic wait_tick(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge MCLK);
      if (TICK === 1'b1) begin
        @(posedge MCLK);
        #1;
        n = n + 1;
        got = 1'b1;
      end else begin
        @(posedge MCLK);
        n = n + 1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: observed no TICK in %0d cycles, required one", n);
    end
  endtask

  task automatic step(input string tag, input int period);
    int n;
    wait_tick(n);
    if (period != 0) chk({tag, "_period"}, n, period);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed lamps %b with no expected entry queued", tag, lamps);
    end else begin
      chk(tag, lamps, sb.pop_front());
    end
  endtask

  task automatic do_reset();
    @(posedge MCLK);
    #1 RESET = 1'b1;
    @(posedge MCLK);
    #1;
    chk("reset_lamps", lamps, L_HG);
    chk("reset_tick", TICK, 1'b0);
    @(posedge MCLK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    // idle after reset: HG held, TICK at 125 then every 250 cycles
    do_reset();
    repeat (20) sb.push_back(L_HG);
    step("idle_first", 125);
    repeat (19) step("idle", 250);

    // highway left-turn request only
    do_reset();
    sb.push_back(L_HG); sb.push_back(L_HG); sb.push_back(L_HY);
    sb.push_back(L_HL); sb.push_back(L_HY); sb.push_back(L_HG);
    step("hs_only", 125);
    #1259 HS_IN = 1'b1;
    step("hs_only", 0);
    step("hs_only", 0);
    step("hs_only", 0);
    HS_IN = 1'b0;
    step("hs_only", 0);
    step("hs_only", 0);

    // farm request only, held for one tick
    sb.push_back(L_HG); sb.push_back(L_HY); sb.push_back(L_FL);
    sb.push_back(L_FY); sb.push_back(L_HG); sb.push_back(L_HG);
    FS_IN = 1'b1;
    step("fs_only", 0);
    FS_IN = 1'b0;
    repeat (5) step("fs_only", 0);

    // both requests together
    sb.push_back(L_HG); sb.push_back(L_HY); sb.push_back(L_HL); sb.push_back(L_HY);
    sb.push_back(L_FL); sb.push_back(L_FY); sb.push_back(L_HG); sb.push_back(L_HG);
    HS_IN = 1'b1;
    FS_IN = 1'b1;
    step("both", 0);
    HS_IN = 1'b0;
    FS_IN = 1'b0;
    repeat (7) step("both", 0);

    // highway request pulsed during HY1 of a farm cycle
    sb.push_back(L_HG); sb.push_back(L_HY); sb.push_back(L_FL); sb.push_back(L_FY);
    sb.push_back(L_HG); sb.push_back(L_HY); sb.push_back(L_HL); sb.push_back(L_HY);
    sb.push_back(L_HG); sb.push_back(L_HG);
    FS_IN = 1'b1;
    step("hs_late", 0);
    FS_IN = 1'b0;
    step("hs_late", 0);
    HS_IN = 1'b1;
    @(posedge MCLK);
    #1 HS_IN = 1'b0;
    repeat (8) step("hs_late", 0);

    // farm pulse during HL, then reset while in FL
    sb.push_back(L_HG); sb.push_back(L_HY); sb.push_back(L_HL);
    sb.push_back(L_HY); sb.push_back(L_FL);
    HS_IN = 1'b1;
    step("fs_in_hl", 0);
    HS_IN = 1'b0;
    step("fs_in_hl", 0);
    step("fs_in_hl", 0);
    FS_IN = 1'b1;
    @(posedge MCLK);
    #1 FS_IN = 1'b0;
    step("fs_in_hl", 0);
    step("fs_in_hl", 0);
    HS_IN = 1'b1;
    @(posedge MCLK);
    #1 HS_IN = 1'b0;
    RESET = 1'b1;
    @(posedge MCLK);
    #1;
    chk("rst_mid_lamps", lamps, L_HG);
    chk("rst_mid_tick", TICK, 1'b0);
    RESET = 1'b0;
    repeat (3) sb.push_back(L_HG);
    step("rst_mid_after", 125);
    step("rst_mid_after", 250);
    step("rst_mid_after", 250);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed simulation still running at 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
